// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM grey-scale generator.
package pwm_pkg;

    typedef enum logic {WAIT_VS, RUN} pwm_state_e;

    localparam logic MODE_FULL  = 1'b0;
    localparam logic MODE_SPLIT = 1'b1;

    function automatic int unsigned line_w(input int unsigned lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

endpackage

// File: rtl/pwm_cmp_bank.sv
// Per-channel threshold derivation and counter compare for the PWM outputs.
module pwm_cmp_bank
    import pwm_pkg::*;
#(
    parameter int unsigned CH      = 16,
    parameter int unsigned GS_BITS = 16
) (
    input  logic                       en,
    input  logic                       mode_q,
    input  logic                       pass,
    input  logic [GS_BITS-1:0]         cnt,
    input  logic [CH-1:0][GS_BITS-1:0] active,
    output logic [CH-1:0]              pwm
);

    for (genvar i = 0; i < CH; i++) begin : g_slice
        logic [GS_BITS-1:0] v;
        logic [GS_BITS-1:0] thr;

        assign v = active[i];

        // Split mode: the odd LSB goes to pass 0 so both passes sum to v.
        always_comb begin
            thr = v;
            if (mode_q == MODE_SPLIT) begin
                thr = (v >> 1) + ((pass == 1'b0) ? {{(GS_BITS-1){1'b0}}, v[0]} : '0);
            end
        end

        assign pwm[i] = en & (cnt < thr);
    end

endmodule

// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM generator: shadow/active line buffers, line FSM and compare bank.
// Define PWM_OUT_REG_EN to register OUT, line_done and frame_done (+1 GCK latency).
module pwm_gen_mc
    import pwm_pkg::*;
#(
    parameter int unsigned CH      = 16,
    parameter int unsigned GS_BITS = 16,
    parameter int unsigned LINES   = 32
) (
    input  logic                     GCK,
    input  logic                     rst_n,
    input  logic                     Vsync,
    input  logic                     out_en,
    input  logic                     mode,
    input  logic                     ld_valid,
    input  logic [GS_BITS-1:0]       ld_data,
    output logic                     ld_ready,
    output logic                     fetch_req,
    output logic [line_w(LINES)-1:0] fetch_line,
    output logic [line_w(LINES)-1:0] line_idx,
    output logic [CH-1:0]            OUT,
    output logic                     line_done,
    output logic                     frame_done,
    output logic                     underrun
);

    localparam int unsigned LW = line_w(LINES);
    localparam int unsigned PW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [GS_BITS-1:0] CNT_FULL_END  = {GS_BITS{1'b1}};
    localparam logic [GS_BITS-1:0] CNT_SPLIT_END = {1'b0, {(GS_BITS-1){1'b1}}};
    localparam logic [LW-1:0]      LAST_LINE     = LW'(LINES - 1);
    localparam logic [PW-1:0]      LAST_WORD     = PW'(CH - 1);

    function automatic logic [LW-1:0] next_line(input logic [LW-1:0] l);
        return (l == LAST_LINE) ? '0 : l + 1'b1;
    endfunction

    pwm_state_e                 state_q, state_d;
    logic [GS_BITS-1:0]         cnt_q, cnt_d;
    logic                       pass_q, pass_d;
    logic                       mode_q, mode_d;
    logic [LW-1:0]              line_d;
    logic                       vsync_q, vs_pulse;
    logic                       swap, underrun_d, pass_end, line_end;
    logic                       started_q, load;
    logic                       shadow_full;
    logic [PW-1:0]              wr_ptr;
    logic [CH-1:0][GS_BITS-1:0] shadow, active;
    logic [CH-1:0]              out_c;

    assign vs_pulse = Vsync & ~vsync_q;
    assign ld_ready = ~shadow_full;
    assign load     = ld_valid & ld_ready;
    assign pass_end = out_en &
        (cnt_q == ((mode_q == MODE_SPLIT) ? CNT_SPLIT_END : CNT_FULL_END));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        mode_d     = mode_q;
        line_d     = line_idx;
        swap       = 1'b0;
        underrun_d = 1'b0;
        line_end   = 1'b0;
        case (state_q)
            WAIT_VS: begin
                if (vs_pulse) begin
                    state_d    = RUN;
                    line_d     = next_line(line_idx);
                    mode_d     = mode;
                    cnt_d      = '0;
                    pass_d     = 1'b0;
                    swap       = shadow_full;
                    underrun_d = ~shadow_full;
                end
            end
            RUN: begin
                if (pass_end) begin
                    cnt_d = '0;
                    if (mode_q == MODE_SPLIT && !pass_q) begin
                        pass_d = 1'b1;
                    end else begin
                        line_end = 1'b1;
                        state_d  = WAIT_VS;
                    end
                end else if (out_en) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = WAIT_VS;
        endcase
    end

    always_ff @(posedge GCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_VS;
            cnt_q      <= '0;
            pass_q     <= 1'b0;
            mode_q     <= MODE_FULL;
            line_idx   <= LAST_LINE;
            vsync_q    <= 1'b0;
            started_q  <= 1'b0;
            fetch_req  <= 1'b0;
            fetch_line <= '0;
            underrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            mode_q    <= mode_d;
            line_idx  <= line_d;
            vsync_q   <= Vsync;
            started_q <= 1'b1;
            // First cycle out of reset requests line 0; afterwards every swap requests the next.
            fetch_req <= ~started_q | swap;
            underrun  <= underrun_d;
            if (swap) begin
                fetch_line <= next_line(line_d);
            end
        end
    end

    always_ff @(posedge GCK or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            active      <= '0;
            shadow_full <= 1'b0;
            wr_ptr      <= '0;
        end else if (swap) begin
            active      <= shadow;
            shadow_full <= 1'b0;
            wr_ptr      <= '0;
        end else if (load) begin
            shadow[wr_ptr] <= ld_data;
            if (wr_ptr == LAST_WORD) begin
                wr_ptr      <= '0;
                shadow_full <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    pwm_cmp_bank #(
        .CH      (CH),
        .GS_BITS (GS_BITS)
    ) u_cmp_bank (
        .en     ((state_q == RUN) & out_en),
        .mode_q (mode_q),
        .pass   (pass_q),
        .cnt    (cnt_q),
        .active (active),
        .pwm    (out_c)
    );

`ifdef PWM_OUT_REG_EN
    logic [CH-1:0] out_q;
    logic          line_done_q, frame_done_q;

    always_ff @(posedge GCK or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_q        <= out_c;
            line_done_q  <= line_end;
            frame_done_q <= line_end & (line_idx == LAST_LINE);
        end
    end

    assign OUT        = out_q;
    assign line_done  = line_done_q;
    assign frame_done = frame_done_q;
`else
    assign OUT        = out_c;
    assign line_done  = line_end;
    assign frame_done = line_end & (line_idx == LAST_LINE);
`endif

endmodule

// File: tb/tb_pwm_gen_mc.sv
// Self-checking bench for pwm_gen_mc: vector table, corner sequences and random lines.
module tb_pwm_gen_mc;

    localparam int CH       = 16;
    localparam int GS       = 4;
    localparam int LINES    = 32;
    localparam int LINE_CNT = 1 << GS;

    logic          GCK = 1'b0;
    logic          rst_n = 1'b0;
    logic          Vsync = 1'b0;
    logic          out_en = 1'b0;
    logic          mode = 1'b0;
    logic          ld_valid = 1'b0;
    logic [GS-1:0] ld_data = '0;
    logic          ld_ready, fetch_req, line_done, frame_done, underrun;
    logic [4:0]    fetch_line, line_idx;
    logic [CH-1:0] OUT;

    int checks = 0;
    int errors = 0;
    int exp_active[CH];
    int sh[CH];
    int pix[CH];
    int hi[CH][2];
    int sh_cnt = 0;
    int exp_line = LINES - 1;
    bit cur_md = 1'b0;

    typedef struct {
        bit md;
        int v0;
        int v1;
        int v2;
        int e0p0;
        int e0p1;
        int e1;
        int e2;
    } vec_t;
    vec_t tbl[5];

    pwm_gen_mc #(
        .CH      (CH),
        .GS_BITS (GS),
        .LINES   (LINES)
    ) dut (
        .GCK        (GCK),
        .rst_n      (rst_n),
        .Vsync      (Vsync),
        .out_en     (out_en),
        .mode       (mode),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .fetch_req  (fetch_req),
        .fetch_line (fetch_line),
        .line_idx   (line_idx),
        .OUT        (OUT),
        .line_done  (line_done),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 GCK = ~GCK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge GCK);
        #1;
    endtask

    // Deassert reset just after an edge; fetch_req must pulse only after the following edge.
    task automatic release_reset();
        rst_n = 1'b1;
        exp_line = LINES - 1;
        sh_cnt = 0;
        for (int i = 0; i < CH; i++) exp_active[i] = 0;
        @(negedge GCK);
        chk("fetch_req_before_edge", int'(fetch_req), 0);
        next_edge();
        @(negedge GCK);
        chk("fetch_req_after_rst", int'(fetch_req), 1);
        chk("fetch_line_after_rst", int'(fetch_line), 0);
        next_edge();
        @(negedge GCK);
        chk("fetch_req_single", int'(fetch_req), 0);
        next_edge();
    endtask

    task automatic load_words(input int n);
        for (int k = 0; k < n; k++) begin
            ld_valid = 1'b1;
            ld_data  = GS'(pix[sh_cnt]);
            @(negedge GCK);
            chk("ld_ready", int'(ld_ready), 1);
            next_edge();
            sh[sh_cnt] = pix[sh_cnt];
            sh_cnt++;
        end
        ld_valid = 1'b0;
        @(negedge GCK);
        chk("ld_ready_after_load", int'(ld_ready), int'(sh_cnt < CH));
        next_edge();
    endtask

    // Vsync edge in WAIT_VS; the following cycle is RUN count 0 with out_en held low.
    task automatic start_line(input bit md);
        bit swap;
        swap   = (sh_cnt == CH);
        Vsync  = 1'b1;
        mode   = md;
        out_en = 1'b0;
        next_edge();
        Vsync  = 1'b0;
        mode   = ~md;
        cur_md = md;
        exp_line = (exp_line + 1) % LINES;
        if (swap) begin
            for (int i = 0; i < CH; i++) exp_active[i] = sh[i];
            sh_cnt = 0;
        end
        @(negedge GCK);
        chk("underrun", int'(underrun), int'(!swap));
        chk("fetch_req", int'(fetch_req), int'(swap));
        if (swap) chk("fetch_line", int'(fetch_line), (exp_line + 1) % LINES);
        chk("line_idx", int'(line_idx), exp_line);
        chk("ld_ready_line_start", int'(ld_ready), 1);
        chk("OUT_en_low", int'(OUT), 0);
        next_edge();
    endtask

    // en_kind: 0 always enabled, 1 random enable, 2 seven-cycle freeze plus a Vsync in RUN.
    task automatic run_line(input int en_kind);
        int k;
        int plen;
        int p;
        int idx;
        int thr;
        bit en;
        bit done;
        bit exp_ld;
        logic [CH-1:0] exp_vec;
        k = 0;
        done = 1'b0;
        plen = cur_md ? LINE_CNT / 2 : LINE_CNT;
        for (int i = 0; i < CH; i++) begin
            hi[i][0] = 0;
            hi[i][1] = 0;
        end
        for (int c = 0; c < 400 && !done; c++) begin
            case (en_kind)
                0:       en = 1'b1;
                1:       en = ($urandom_range(3) != 0);
                default: en = !(c >= 5 && c < 12);
            endcase
            out_en = en;
            Vsync  = (en_kind == 2 && c == 8);
            @(negedge GCK);
            p = k / plen;
            idx = k % plen;
            exp_vec = '0;
            if (en) begin
                for (int i = 0; i < CH; i++) begin
                    if (!cur_md) thr = exp_active[i];
                    else if (p == 0) thr = (exp_active[i] + 1) / 2;
                    else thr = exp_active[i] / 2;
                    exp_vec[i] = (idx < thr);
                end
            end
            exp_ld = en && (k == LINE_CNT - 1);
            chk("OUT", int'(OUT), int'(exp_vec));
            chk("line_done", int'(line_done), int'(exp_ld));
            chk("frame_done", int'(frame_done), int'(exp_ld && exp_line == LINES - 1));
            chk("line_idx_run", int'(line_idx), exp_line);
            if (en) begin
                for (int i = 0; i < CH; i++) hi[i][p] += int'(OUT[i]);
            end
            next_edge();
            if (en) k++;
            done = (k == LINE_CNT);
        end
        Vsync  = 1'b0;
        out_en = 1'b1;
        if (!done) chk("line_timeout", k, LINE_CNT);
        @(negedge GCK);
        chk("OUT_idle", int'(OUT), 0);
        chk("line_done_idle", int'(line_done), 0);
        next_edge();
    endtask

    initial begin
        tbl[0] = '{1'b0, 5, 0, 15, 5, 0, 0, 15};
        tbl[1] = '{1'b1, 5, 0, 15, 3, 2, 0, 15};
        tbl[2] = '{1'b1, 15, 1, 8, 8, 7, 1, 8};
        tbl[3] = '{1'b0, 1, 14, 7, 1, 0, 14, 7};
        tbl[4] = '{1'b1, 0, 15, 1, 0, 0, 15, 1};

        repeat (3) next_edge();
        @(negedge GCK);
        chk("rst_OUT", int'(OUT), 0);
        chk("rst_ld_ready", int'(ld_ready), 1);
        chk("rst_fetch_req", int'(fetch_req), 0);
        chk("rst_fetch_line", int'(fetch_line), 0);
        chk("rst_line_idx", int'(line_idx), LINES - 1);
        chk("rst_line_done", int'(line_done), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_underrun", int'(underrun), 0);
        next_edge();
        release_reset();

        for (int r = 0; r < 5; r++) begin
            for (int i = 3; i < CH; i++) pix[i] = i;
            pix[0] = tbl[r].v0;
            pix[1] = tbl[r].v1;
            pix[2] = tbl[r].v2;
            load_words(CH);
            start_line(tbl[r].md);
            run_line(0);
            chk("tbl_ch0_pass0", hi[0][0], tbl[r].e0p0);
            chk("tbl_ch0_pass1", hi[0][1], tbl[r].e0p1);
            chk("tbl_ch1_total", hi[1][0] + hi[1][1], tbl[r].e1);
            chk("tbl_ch2_total", hi[2][0] + hi[2][1], tbl[r].e2);
        end

        // Partial load: underrun replays the previous line; the rest completes the shadow later.
        for (int i = 0; i < CH; i++) pix[i] = int'($urandom_range(15));
        load_words(10);
        start_line(1'b0);
        run_line(0);
        load_words(CH - 10);
        start_line(1'b1);
        run_line(2);
        start_line(1'b0);
        run_line(2);

        for (int l = 0; l < LINES; l++) begin
            for (int i = 0; i < CH; i++) pix[i] = int'($urandom_range(15));
            load_words(CH);
            start_line(bit'($urandom_range(1)));
            run_line(1);
        end

        // Reset mid-line.
        for (int i = 0; i < CH; i++) pix[i] = (i == 2) ? 15 : int'($urandom_range(15));
        load_words(CH);
        start_line(1'b0);
        out_en = 1'b1;
        @(negedge GCK);
        chk("OUT2_before_rst", int'(OUT[2]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("OUT_async_rst", int'(OUT), 0);
        chk("line_idx_async_rst", int'(line_idx), LINES - 1);
        chk("fetch_line_async_rst", int'(fetch_line), 0);
        chk("ld_ready_async_rst", int'(ld_ready), 1);
        next_edge();
        release_reset();
        for (int i = 0; i < CH; i++) pix[i] = int'($urandom_range(15));
        load_words(CH);
        start_line(1'b1);
        run_line(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
